// File: rtl/vga_stream.sv
// Raster timing generator and frame-buffer pixel streamer. Fetch counters drive the
// read port; a MEM_LATENCY-deep tag pipeline realigns timing with the returned pixel data.
module vga_stream #(
    parameter int H_BITS      = 10,
    parameter int V_BITS      = 10,
    parameter int COLOR_BITS  = 3,
    parameter int ADDR_BITS   = 20,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  pix_en,
    input  logic [H_BITS-1:0]     h_active,
    input  logic [H_BITS-1:0]     h_fp,
    input  logic [H_BITS-1:0]     h_sync,
    input  logic [H_BITS-1:0]     h_bp,
    input  logic [V_BITS-1:0]     v_active,
    input  logic [V_BITS-1:0]     v_fp,
    input  logic [V_BITS-1:0]     v_sync,
    input  logic [V_BITS-1:0]     v_bp,
    input  logic [ADDR_BITS-1:0]  stride,
    input  logic                  hs_pol,
    input  logic                  vs_pol,
    input  logic [COLOR_BITS-1:0] clear,
    input  logic [COLOR_BITS-1:0] pixel,
    output logic [ADDR_BITS-1:0]  req_addr,
    output logic                  req_valid,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [COLOR_BITS-1:0] RGB,
    output logic                  frame_start,
    output logic                  frame_end
);

    localparam logic [H_BITS-1:0] H_ONE = {{(H_BITS-1){1'b0}}, 1'b1};
    localparam logic [V_BITS-1:0] V_ONE = {{(V_BITS-1){1'b0}}, 1'b1};
    localparam int SUM_W  = (ADDR_BITS > H_BITS) ? ADDR_BITS : H_BITS;
    localparam int TAG_W  = 5;
    localparam int T_VIS  = 4;
    localparam int T_HS   = 3;
    localparam int T_VS   = 2;
    localparam int T_FRST = 1;
    localparam int T_LAST = 0;

    logic                  r_load_pend;
    logic [H_BITS-1:0]     r_h_active, r_h_fp, r_h_sync, r_h_bp;
    logic [V_BITS-1:0]     r_v_active, r_v_fp, r_v_sync, r_v_bp;
    logic [ADDR_BITS-1:0]  r_stride;
    logic                  r_hs_pol, r_vs_pol;

    logic [H_BITS-1:0]     r_fx;
    logic [V_BITS-1:0]     r_fy;
    logic [ADDR_BITS-1:0]  r_line_base;
    logic [TAG_W-1:0]      r_tag_p [MEM_LATENCY];

    logic [H_BITS-1:0]     w_h_active, w_h_fp, w_h_sync, w_h_bp;
    logic [V_BITS-1:0]     w_v_active, w_v_fp, w_v_sync, w_v_bp;
    logic [ADDR_BITS-1:0]  w_stride;
    logic                  w_hs_pol, w_vs_pol;
    logic [H_BITS-1:0]     w_h_total, w_hs_start, w_hs_end;
    logic [V_BITS-1:0]     w_v_total, w_vs_start, w_vs_end;
    logic                  w_fx_wrap, w_fy_wrap, w_vis, w_hs_raw, w_vs_raw;
    logic                  w_first, w_last;
    logic [SUM_W-1:0]      w_addr_sum;
    logic [TAG_W-1:0]      w_tag, w_out;

    // Until the first tick after reset the shadows are stale, so the live inputs are used directly.
    assign w_h_active = r_load_pend ? h_active : r_h_active;
    assign w_h_fp     = r_load_pend ? h_fp     : r_h_fp;
    assign w_h_sync   = r_load_pend ? h_sync   : r_h_sync;
    assign w_h_bp     = r_load_pend ? h_bp     : r_h_bp;
    assign w_v_active = r_load_pend ? v_active : r_v_active;
    assign w_v_fp     = r_load_pend ? v_fp     : r_v_fp;
    assign w_v_sync   = r_load_pend ? v_sync   : r_v_sync;
    assign w_v_bp     = r_load_pend ? v_bp     : r_v_bp;
    assign w_stride   = r_load_pend ? stride   : r_stride;
    assign w_hs_pol   = r_load_pend ? hs_pol   : r_hs_pol;
    assign w_vs_pol   = r_load_pend ? vs_pol   : r_vs_pol;

    assign w_hs_start = w_h_active + w_h_fp;
    assign w_hs_end   = w_hs_start + w_h_sync;
    assign w_h_total  = w_hs_end + w_h_bp;
    assign w_vs_start = w_v_active + w_v_fp;
    assign w_vs_end   = w_vs_start + w_v_sync;
    assign w_v_total  = w_vs_end + w_v_bp;

    assign w_fx_wrap  = (r_fx == w_h_total - H_ONE);
    assign w_fy_wrap  = (r_fy == w_v_total - V_ONE);
    assign w_vis      = (r_fx < w_h_active) && (r_fy < w_v_active);
    assign w_hs_raw   = (r_fx >= w_hs_start) && (r_fx < w_hs_end);
    assign w_vs_raw   = (r_fy >= w_vs_start) && (r_fy < w_vs_end);
    assign w_first    = w_vis && (r_fx == '0) && (r_fy == '0);
    assign w_last     = w_vis && (r_fx == w_h_active - H_ONE) && (r_fy == w_v_active - V_ONE);

    assign w_addr_sum = SUM_W'(r_line_base) + SUM_W'(r_fx);
    assign req_addr   = srst ? '0 : w_addr_sum[ADDR_BITS-1:0];
    assign req_valid  = !srst && w_vis;

    assign w_tag = {w_vis, w_hs_raw, w_vs_raw, w_first, w_last};
    assign w_out = r_tag_p[MEM_LATENCY-1];

    always_ff @(posedge clk) begin
        if (!srst && pix_en && (r_load_pend || (w_fx_wrap && w_fy_wrap))) begin
            r_h_active <= h_active;
            r_h_fp     <= h_fp;
            r_h_sync   <= h_sync;
            r_h_bp     <= h_bp;
            r_v_active <= v_active;
            r_v_fp     <= v_fp;
            r_v_sync   <= v_sync;
            r_v_bp     <= v_bp;
            r_stride   <= stride;
            r_hs_pol   <= hs_pol;
            r_vs_pol   <= vs_pol;
        end
    end

    // Fetch stage: raster counters and running line base address
    always_ff @(posedge clk) begin
        if (srst) begin
            r_load_pend <= 1'b1;
            r_fx        <= '0;
            r_fy        <= '0;
            r_line_base <= '0;
        end else if (pix_en) begin
            r_load_pend <= 1'b0;
            if (w_fx_wrap) begin
                r_fx <= '0;
                if (w_fy_wrap) begin
                    r_fy        <= '0;
                    r_line_base <= '0;
                end else begin
                    r_fy <= r_fy + V_ONE;
                    if (r_fy < w_v_active)
                        r_line_base <= r_line_base + w_stride;
                end
            end else begin
                r_fx <= r_fx + H_ONE;
            end
        end
    end

    // Latency stages: tags ride alongside the outstanding frame-buffer read
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < MEM_LATENCY; i++)
                r_tag_p[i] <= '0;
        end else if (pix_en) begin
            r_tag_p[0] <= w_tag;
            for (int i = 1; i < MEM_LATENCY; i++)
                r_tag_p[i] <= r_tag_p[i-1];
        end
    end

    // Output stage: registered video pins and one-clk frame markers
    always_ff @(posedge clk) begin
        if (srst) begin
            de          <= 1'b0;
            RGB         <= clear;
            hsync       <= ~hs_pol;
            vsync       <= ~vs_pol;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            if (pix_en) begin
                de          <= w_out[T_VIS];
                RGB         <= w_out[T_VIS] ? pixel : '0;
                hsync       <= w_out[T_HS] ? w_hs_pol : ~w_hs_pol;
                vsync       <= w_out[T_VS] ? w_vs_pol : ~w_vs_pol;
                frame_start <= w_out[T_FRST];
                frame_end   <= w_out[T_LAST];
            end
        end
    end

endmodule

// File: tb/tb_vga_stream.sv
// Directed bench for vga_stream: 8x6 raster (4 visible x 3 lines), two-tick memory model.
module tb_vga_stream;

    localparam int HB = 10;
    localparam int VB = 10;
    localparam int CB = 3;
    localparam int AB = 20;
    localparam int ML = 2;

    logic          clk = 1'b0;
    logic          srst, pix_en;
    logic [HB-1:0] h_active, h_fp, h_sync, h_bp;
    logic [VB-1:0] v_active, v_fp, v_sync, v_bp;
    logic [AB-1:0] stride;
    logic          hs_pol, vs_pol;
    logic [CB-1:0] clear, pixel;
    logic [AB-1:0] req_addr;
    logic          req_valid, hsync, vsync, de, frame_start, frame_end;
    logic [CB-1:0] RGB;

    logic [AB-1:0] mem_q0, mem_q1;
    logic          pre_valid;
    logic [AB-1:0] pre_addr;
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    vga_stream #(
        .H_BITS(HB), .V_BITS(VB), .COLOR_BITS(CB), .ADDR_BITS(AB), .MEM_LATENCY(ML)
    ) dut (
        .clk(clk), .srst(srst), .pix_en(pix_en),
        .h_active(h_active), .h_fp(h_fp), .h_sync(h_sync), .h_bp(h_bp),
        .v_active(v_active), .v_fp(v_fp), .v_sync(v_sync), .v_bp(v_bp),
        .stride(stride), .hs_pol(hs_pol), .vs_pol(vs_pol),
        .clear(clear), .pixel(pixel),
        .req_addr(req_addr), .req_valid(req_valid),
        .hsync(hsync), .vsync(vsync), .de(de), .RGB(RGB),
        .frame_start(frame_start), .frame_end(frame_end)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive at the falling edge (memory model included), sample 1 time unit after the rising edge.
    task automatic step(input logic pe);
        @(negedge clk);
        pix_en = pe;
        if (pe) begin
            pixel  = mem_q1[CB-1:0];
            mem_q1 = mem_q0;
            mem_q0 = req_addr;
        end
        pre_valid = req_valid;
        pre_addr  = req_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [CB-1:0] clr);
        srst   = 1'b1;
        clear  = clr;
        mem_q0 = '0;
        mem_q1 = '0;
        repeat (3) step(1'b1);
        srst = 1'b0;
        #1;
    endtask

    task automatic std_cfg();
        h_active = 4; h_fp = 1; h_sync = 2; h_bp = 1;
        v_active = 3; v_fp = 1; v_sync = 1; v_bp = 1;
        stride = 4; hs_pol = 1'b0; vs_pol = 1'b0;
    endtask

    int n_req, de_cnt, fs_cnt, fe_cnt, hs_low, fs_at, fe_at;
    int f, fr, x, y, e_de, e_hs, e_vs, e_rgb, e_fs, e_fe;
    logic [AB-1:0] got_addr [12];
    logic [AB-1:0] exp_stride [12];

    initial begin
        exp_stride = '{0, 1, 2, 3, 16, 17, 18, 19, 32, 33, 34, 35};
        std_cfg();
        pixel = '0; pix_en = 1'b0; mem_q0 = '0; mem_q1 = '0;

        // Reset state
        srst = 1'b1; clear = 3'd2;
        repeat (3) step(1'b1);
        chk("rst_rgb", 32'(RGB), 2);
        chk("rst_de", 32'(de), 0);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_fe", 32'(frame_end), 0);
        chk("rst_valid", 32'(req_valid), 0);
        chk("rst_addr", 32'(req_addr), 0);
        srst = 1'b0;
        #1;
        chk("rel_valid", 32'(req_valid), 1);
        chk("rel_addr", 32'(req_addr), 0);

        // Basic frame and latency alignment over two frames
        n_req = 0; de_cnt = 0; fs_cnt = 0; fe_cnt = 0;
        for (int k = 0; k < 96; k++) begin
            step(1'b1);
            if (pre_valid) begin
                chk("basic_addr", 32'(pre_addr), n_req % 12);
                n_req++;
            end
            f = k - ML;
            e_de = 0; e_hs = 1; e_vs = 1; e_rgb = 0; e_fs = 0; e_fe = 0;
            if (f >= 0) begin
                fr = f % 48; x = fr % 8; y = fr / 8;
                e_de  = (x < 4 && y < 3) ? 1 : 0;
                e_hs  = (x == 5 || x == 6) ? 0 : 1;
                e_vs  = (y == 4) ? 0 : 1;
                e_rgb = e_de ? ((4 * y + x) % 8) : 0;
                e_fs  = (x == 0 && y == 0) ? 1 : 0;
                e_fe  = (x == 3 && y == 2) ? 1 : 0;
            end
            chk("basic_de", 32'(de), e_de);
            chk("basic_hsync", 32'(hsync), e_hs);
            chk("basic_vsync", 32'(vsync), e_vs);
            chk("basic_rgb", 32'(RGB), e_rgb);
            chk("basic_fs", 32'(frame_start), e_fs);
            chk("basic_fe", 32'(frame_end), e_fe);
            de_cnt += int'(de); fs_cnt += int'(frame_start); fe_cnt += int'(frame_end);
        end
        chk("basic_nreq", n_req, 24);
        chk("basic_de_cnt", de_cnt, 24);
        chk("basic_fs_cnt", fs_cnt, 2);
        chk("basic_fe_cnt", fe_cnt, 2);

        // Stride 16
        stride = 16;
        do_reset(3'd2);
        n_req = 0;
        for (int k = 0; k < 48; k++) begin
            step(1'b1);
            if (pre_valid) begin
                if (n_req < 12) got_addr[n_req] = pre_addr;
                n_req++;
            end
        end
        chk("stride_nreq", n_req, 12);
        for (int i = 0; i < 12; i++)
            chk("stride_addr", 32'(got_addr[i]), 32'(exp_stride[i]));

        // pix_en every 4th clk: everything stretches x4, pulses stay one clk
        std_cfg();
        do_reset(3'd2);
        de_cnt = 0; fs_cnt = 0; fe_cnt = 0; hs_low = 0; fs_at = -1; fe_at = -1;
        for (int c = 0; c < 192; c++) begin
            step((c % 4) == 0);
            de_cnt += int'(de);
            hs_low += int'(!hsync);
            if (frame_start) begin fs_cnt++; fs_at = c; end
            if (frame_end) begin fe_cnt++; fe_at = c; end
        end
        chk("gate_de_clks", de_cnt, 48);
        chk("gate_hs_low_clks", hs_low, 44);
        chk("gate_fs_cnt", fs_cnt, 1);
        chk("gate_fe_cnt", fe_cnt, 1);
        chk("gate_fs_at", fs_at, 8);
        chk("gate_fe_at", fe_at, 84);

        // Config shadowing: h_active 4 -> 6 mid-frame
        std_cfg();
        do_reset(3'd2);
        n_req = 0; de_cnt = 0;
        for (int t = 0; t < 108; t++) begin
            if (t == 10) h_active = 6;
            step(1'b1);
            if (t < 48) n_req += int'(pre_valid);
            else        de_cnt += int'(pre_valid);
            if (t == 12) chk("shadow_old_x4", 32'(pre_valid), 0);
            if (t == 52) begin
                chk("shadow_new_x4_valid", 32'(pre_valid), 1);
                chk("shadow_new_x4_addr", 32'(pre_addr), 4);
            end
            if (t == 57) chk("shadow_new_x9", 32'(pre_valid), 0);
            if (t == 58) chk("shadow_line1_addr", 32'(pre_addr), 4);
        end
        chk("shadow_frame0_req", n_req, 12);
        chk("shadow_frame1_req", de_cnt, 18);

        // Reset mid-frame at fy=1, fx=2
        std_cfg();
        do_reset(3'd2);
        repeat (10) step(1'b1);
        srst = 1'b1; clear = 3'd5; hs_pol = 1'b1;
        #1;
        chk("mid_valid_in_rst", 32'(req_valid), 0);
        step(1'b1);
        chk("mid_rgb", 32'(RGB), 5);
        chk("mid_de", 32'(de), 0);
        chk("mid_hsync", 32'(hsync), 0);
        chk("mid_vsync", 32'(vsync), 1);
        chk("mid_fs", 32'(frame_start), 0);
        chk("mid_addr", 32'(req_addr), 0);
        srst = 1'b0;
        #1;
        chk("mid_rel_valid", 32'(req_valid), 1);
        chk("mid_rel_addr", 32'(req_addr), 0);
        for (int k = 0; k < 9; k++) begin
            step(1'b1);
            if (k == 1) chk("mid_restart_addr1", 32'(pre_addr), 1);
            if (k == 6) chk("mid_pol_idle", 32'(hsync), 0);
            if (k == 7) chk("mid_pol_active", 32'(hsync), 1);
        end

        // Zero-width active region
        std_cfg();
        h_active = 0;
        do_reset(3'd2);
        n_req = 0; de_cnt = 0; hs_low = 0; fs_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            step(1'b1);
            n_req  += int'(pre_valid);
            de_cnt += int'(de);
            hs_low += int'(!hsync);
            fs_cnt += int'(frame_start);
        end
        chk("zero_req", n_req, 0);
        chk("zero_de", de_cnt, 0);
        chk("zero_hs_low", hs_low, 11);
        chk("zero_fs", fs_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_stream.md
# vga_stream

Parametrised raster timing generator and pixel streamer, the next generation of our VGA output block. It adds configurable counter, colour and address widths, a pixel-clock enable for single-clock operation, and fixed-latency compensation for the external frame-buffer read. It also adds a line stride, selectable sync polarity, and per-frame shadowing of the runtime configuration. It sits between the external frame-buffer read port and the board video pins.

## Interface
Parameters:
- H_BITS, 10, width of horizontal counter and all horizontal config fields
- V_BITS, 10, width of vertical counter and all vertical config fields
- COLOR_BITS, 3, pixel/RGB width
- ADDR_BITS, 20, frame-buffer address width
- MEM_LATENCY, 1, pix_en ticks from request to pixel data; legal range 1..8

Ports:
- clk  in  1  single clock; all logic on posedge
- srst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel tick; all state advances only when high
- h_active, h_fp, h_sync, h_bp  in  H_BITS each  horizontal visible, front porch, sync, back porch (pixels)
- v_active, v_fp, v_sync, v_bp  in  V_BITS each  vertical equivalents (lines)
- stride  in  ADDR_BITS  address increment between visible lines
- hs_pol, vs_pol  in  1 each  active level of hsync/vsync
- clear  in  COLOR_BITS  colour driven on RGB during reset
- pixel  in  COLOR_BITS  frame-buffer read data
- req_addr  out  ADDR_BITS  read address
- req_valid  out  1  request is for a visible pixel
- hsync, vsync  out  1 each  registered sync outputs
- de  out  1  registered data enable (visible)
- RGB  out  COLOR_BITS  registered pixel output
- frame_start, frame_end  out  1 each  single-clk pulses

## Operation
- Shadow registers capture all config inputs on the first pix_en tick after srst deasserts, and on the final tick of every frame (fetch x = h_total-1, y = v_total-1). Between captures, config input changes have no effect.
- h_total = h_active+h_fp+h_sync+h_bp, computed in H_BITS. v_total is computed likewise in V_BITS. Overflow is illegal config; behaviour is undefined, no detection required.
- Fetch counters fx (0..h_total-1) and fy (0..v_total-1) advance one per pix_en. fx wraps to 0 and increments fy; fy wraps to 0 at the frame end.
- Fetch visible = fx < h_active && fy < v_active. req_valid = fetch visible (combinational from counters).
- Address: req_addr = line_base + fx, truncated to ADDR_BITS. No multiplier. line_base += stride when fx wraps on a visible line (fy < v_active). line_base = 0 at the frame wrap. Address wraps modulo 2^ADDR_BITS.
- Fetch-side sync: hs_raw = h_active+h_fp <= fx < h_active+h_fp+h_sync. vs_raw uses the same form on fy.
- Pipeline: {visible, hs_raw, vs_raw, first, last} pass through a MEM_LATENCY-deep shift register, advanced on pix_en only.
  - first = (fx,fy)=(0,0) with the frame visible.
  - last = fetch at (h_active-1, v_active-1).
- At each pix_en, from the pipeline output stage:
  - de <= visible
  - RGB <= visible ? pixel : 0
  - hsync <= hs_raw ? hs_pol : !hs_pol
  - vsync <= vs_raw ? vs_pol : !vs_pol
- frame_start and frame_end are high for exactly one clk: the cycle following the pix_en edge that registers the first/last pixel. They are 0 in every other cycle, including stalled cycles with pix_en low.
- Zero-size active region (h_active or v_active = 0): no req_valid, de stays 0, sync timing continues.

## Timing
- Reset values: fx=fy=0, line_base=0, pipeline cleared, req_addr=0, req_valid=0 during srst, de=0, RGB=clear, hsync=!hs_pol, vsync=!vs_pol, frame_start=frame_end=0.
- After srst falls, req_valid rises combinationally, with addr 0 (given h_active, v_active > 0).
- Memory contract: pixel must hold data for the address presented at tick t when tick t+MEM_LATENCY occurs.
- RGB/de/syncs for fetch tick t update at the clk edge of tick t+MEM_LATENCY. Output latency from request is MEM_LATENCY ticks plus the register.
- pix_en low: all counters, pipeline and outputs hold. Pulses drop after one clk.
- srst asserted mid-frame: takes effect at the next clk edge regardless of pix_en. The frame is abandoned and shadow config is reloaded on the next tick.

## Test plan
- Basic frame: MEM_LATENCY=2, pix_en=1, h config 4/1/2/1, v config 3/1/1/1, stride=4. Per frame, req_addr visible sequence must be 0..11. hsync (hs_pol=0) must be low for 2 clk starting 7 clks after the line's first request. The frame repeats every 48 clk.
- Latency alignment: memory model returns pixel = addr[2:0], 2 ticks delayed. de must be high exactly 12 clks per frame, and RGB must match 0,1,2,3,4,... in order.
- Stride: stride=16, same config. Line bases must be 0, 16, 32; addresses 0-3, 16-19, 32-35.
- pix_en gating: pix_en high every 4th clk. All outputs must stretch ×4. frame_start/frame_end must still be exactly 1 clk wide, once per frame.
- Config shadowing: change h_active 4→6 mid-frame. The current frame must keep 4. The next frame must use 6 from fx=0.
- Reset mid-frame: assert srst at fy=1, fx=2 with clear=5. Next edge must show RGB=5, de=0, syncs inactive. On release, req_addr must restart at 0.
